// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 driver: command bytes, the frame FSM
// state type and the hex-to-7-segment decoder.
package tm1638_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP       = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_SHIFT_OUT,
    ST_GAP,
    ST_WAIT_KEY,
    ST_SHIFT_IN,
    ST_DONE
  } state_t;

  // Common-cathode segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h58;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tm1638_bit_engine.sv
// Byte-serial shifter for the TM1638 link, LSB first.
// Ports:
//   clkinput, rst      system clock, synchronous active-high reset
//   start, rx_mode,    pending-byte request held by the sequencer; consumed
//   tx_byte            when idle or at the end of the current byte
//   dio_in             serial readback, sampled on the cycle sclk rises
//   sclk, dio_out,     registered pin drivers (sclk idles high)
//   dio_oe
//   ack                one-cycle pulse when a requested byte is taken
//   rx_valid, rx_byte  received byte, pulsed when a read byte completes
//   last_c             combinational: this cycle ends the final bit cell and
//                      no further byte is pending
module tm1638_bit_engine
  import tm1638_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clkinput,
  input  logic       rst,
  input  logic       start,
  input  logic       rx_mode,
  input  logic [7:0] tx_byte,
  input  logic       dio_in,
  output logic       sclk,
  output logic       dio_out,
  output logic       dio_oe,
  output logic       ack,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       last_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          busy_q;
  logic          rx_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    txr;
  logic [7:0]    rxr;
  logic          cell_end;

  // Final cycle of a high phase: the bit cell closes on the coming edge.
  assign cell_end = busy_q && sclk && (cnt == CW'(CLK_DIV - 1));
  assign last_c   = cell_end && (bitn == 3'd7) && !start;

  always_ff @(posedge clkinput) begin
    if (rst) begin
      sclk     <= 1'b1;
      dio_out  <= 1'b0;
      dio_oe   <= 1'b0;
      ack      <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= 8'h00;
      busy_q   <= 1'b0;
      rx_q     <= 1'b0;
      cnt      <= '0;
      bitn     <= 3'd0;
      txr      <= 8'h00;
      rxr      <= 8'h00;
    end else begin
      ack      <= 1'b0;
      rx_valid <= 1'b0;
      if (!busy_q || (cell_end && (bitn == 3'd7))) begin
        // Byte boundary: hand up a received byte, then chain the next one.
        if (busy_q && rx_q) begin
          rx_byte  <= rxr;
          rx_valid <= 1'b1;
        end
        if (start) begin
          busy_q  <= 1'b1;
          rx_q    <= rx_mode;
          txr     <= tx_byte;
          bitn    <= 3'd0;
          cnt     <= '0;
          sclk    <= 1'b0;
          ack     <= 1'b1;
          dio_oe  <= !rx_mode;
          dio_out <= rx_mode ? 1'b0 : tx_byte[0];
        end else begin
          busy_q <= 1'b0;
          dio_oe <= 1'b0;
        end
      end else if (!sclk) begin
        // Low phase: rise after CLK_DIV cycles, capturing readback.
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt  <= '0;
          sclk <= 1'b1;
          if (rx_q) rxr <= {dio_in, rxr[7:1]};
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // High phase of a non-final bit: fall and present the next bit.
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt  <= '0;
          sclk <= 1'b0;
          bitn <= bitn + 3'd1;
          if (!rx_q) dio_out <= txr[3'(bitn + 3'd1)];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tm1638_driver.sv
// Free-running TM1638 frame sequencer: refreshes digits, LEDs and display
// control every frame and optionally reads the 32-bit key matrix.
// Ports:
//   clkinput, rst                  system clock, synchronous active-high reset
//   seg_data, dp, led              per-digit hex nibble, decimal point, LED
//   brightness, display_on         display control command fields
//   clk, stb, dio_out, dio_oe      serial clock, strobe (active low), data out
//   dio_in                         data readback from the board
//   keys, keys_valid               last key bytes and their update pulse
//   busy                           frame in progress (stb low or inner gap)
module tm1638_driver
  import tm1638_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned KEY_SCAN   = 1,
  parameter int unsigned WAIT_TICKS = 8
) (
  input  logic                      clkinput,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   seg_data,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     led,
  input  logic [2:0]                brightness,
  input  logic                      display_on,
  output logic                      clk,
  output logic                      stb,
  output logic                      dio_out,
  output logic                      dio_oe,
  input  logic                      dio_in,
  output logic [31:0]               keys,
  output logic                      keys_valid,
  output logic                      busy
);

  localparam int unsigned CNT_MAX = (2 * CLK_DIV > WAIT_TICKS) ? 2 * CLK_DIV : WAIT_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [1:0]       cmd;
  logic [4:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      seg_q;
  logic [7:0]       dp_q;
  logic [7:0]       led_q;
  logic             on_q;
  logic [2:0]       brt_q;
  logic [31:0]      shadow;
  logic [1:0]       rx_cnt;
  logic [1:0]       ack_cnt;
  logic             eng_start;
  logic             eng_rx;
  logic [7:0]       eng_tx;
  logic             eng_ack;
  logic             eng_rx_valid;
  logic [7:0]       eng_rx_byte;
  logic             eng_last_c;

  // Byte i of command c, built from the frame snapshot. Command 1 is the
  // address byte followed by 16 data bytes (segment/dp, then LED, per digit).
  function automatic logic [7:0] frame_byte(input logic [1:0] c, input logic [4:0] i);
    logic [3:0] k;
    logic [2:0] pos;
    logic [7:0] seg;
    logic [7:0] b;
    k   = 4'(i - 5'd1);
    pos = k[3:1];
    seg = hex2seg(seg_q[{pos, 2'b00} +: 4]);
    b   = 8'h00;
    case (c)
      2'd0: b = CMD_WRITE_AUTO;
      2'd1: begin
        if (i == 5'd0) b = CMD_ADDR0;
        else if (32'(pos) < NUM_DIGITS) b = k[0] ? {7'b0, led_q[pos]} : {dp_q[pos], seg[6:0]};
      end
      2'd2: b = CMD_DISP | {4'b0, on_q, brt_q};
      default: b = CMD_READ_KEYS;
    endcase
    return b;
  endfunction

  tm1638_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clkinput (clkinput),
    .rst      (rst),
    .start    (eng_start),
    .rx_mode  (eng_rx),
    .tx_byte  (eng_tx),
    .dio_in   (dio_in),
    .sclk     (clk),
    .dio_out  (dio_out),
    .dio_oe   (dio_oe),
    .ack      (eng_ack),
    .rx_valid (eng_rx_valid),
    .rx_byte  (eng_rx_byte),
    .last_c   (eng_last_c)
  );

  // Frame sequencer; reset lands in LOAD so the first frame starts at once.
  always_ff @(posedge clkinput) begin
    if (rst) begin
      state      <= ST_LOAD;
      stb        <= 1'b1;
      busy       <= 1'b0;
      keys       <= 32'h0;
      keys_valid <= 1'b0;
      cmd        <= 2'd0;
      idx        <= 5'd0;
      cnt        <= '0;
      seg_q      <= 32'h0;
      dp_q       <= 8'h00;
      led_q      <= 8'h00;
      on_q       <= 1'b0;
      brt_q      <= 3'd0;
      shadow     <= 32'h0;
      rx_cnt     <= 2'd0;
      ack_cnt    <= 2'd0;
      eng_start  <= 1'b0;
      eng_rx     <= 1'b0;
      eng_tx     <= 8'h00;
    end else begin
      keys_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            cnt   <= '0;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          seg_q <= 32'(seg_data);
          dp_q  <= 8'(dp);
          led_q <= 8'(led);
          on_q  <= display_on;
          brt_q <= brightness;
          cmd   <= 2'd0;
          state <= ST_START;
        end
        ST_START: begin
          stb       <= 1'b0;
          busy      <= 1'b1;
          eng_start <= 1'b1;
          eng_rx    <= 1'b0;
          eng_tx    <= frame_byte(cmd, 5'd0);
          idx       <= 5'd0;
          state     <= ST_SHIFT_OUT;
        end
        ST_SHIFT_OUT: begin
          // Keep one byte queued ahead so data bytes run back to back.
          if (eng_ack) begin
            if (cmd == 2'd1 && idx != 5'd16) begin
              idx    <= idx + 5'd1;
              eng_tx <= frame_byte(cmd, idx + 5'd1);
            end else begin
              eng_start <= 1'b0;
            end
          end
          if (eng_last_c) begin
            cnt <= '0;
            if (cmd == 2'd3) begin
              state <= ST_WAIT_KEY;
            end else begin
              stb <= 1'b1;
              if (cmd == 2'd2 && KEY_SCAN == 0) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                cmd   <= cmd + 2'd1;
                state <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(2 * CLK_DIV - 2)) begin
            cnt   <= '0;
            state <= ST_START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_KEY: begin
          if (cnt == CNT_W'(WAIT_TICKS - 1)) begin
            cnt       <= '0;
            eng_start <= 1'b1;
            eng_rx    <= 1'b1;
            ack_cnt   <= 2'd0;
            rx_cnt    <= 2'd0;
            state     <= ST_SHIFT_IN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SHIFT_IN: begin
          // Four read bytes chained; byte 0 ends up in shadow[7:0].
          if (eng_ack) begin
            if (ack_cnt == 2'd3) eng_start <= 1'b0;
            ack_cnt <= ack_cnt + 2'd1;
          end
          if (eng_rx_valid) begin
            shadow <= {eng_rx_byte, shadow[31:8]};
            rx_cnt <= rx_cnt + 2'd1;
            if (rx_cnt == 2'd3) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          keys       <= shadow;
          keys_valid <= 1'b1;
          stb        <= 1'b1;
          busy       <= 1'b0;
          cnt        <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_driver.sv
// Self-checking bench for tm1638_driver: decodes the serial stream per strobe
// window, plays a TM1638 key-matrix device, and compares every frame with a
// byte-list model built from the input values.
module tb_tm1638_driver;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned NDIG       = 4;
  localparam int unsigned WAIT_TICKS = 3;

  logic        clkinput = 1'b0;
  logic        rst;
  logic [15:0] seg_data;
  logic [3:0]  dp;
  logic [3:0]  led;
  logic [2:0]  brightness;
  logic        display_on;
  logic        sclk;
  logic        stb;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in;
  logic [31:0] keys;
  logic        keys_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h58, 8'h5E, 8'h79, 8'h71};
  logic [7:0]  dev_key [4];
  logic [7:0]  wr_q [$];
  int          win_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  old_q [$];
  logic [31:0] exp_keys;
  logic [31:0] old_keys;
  int          kv_cnt = 0;
  int          oe_viol = 0;

  tm1638_driver #(
    .CLK_DIV    (CLK_DIV),
    .NUM_DIGITS (NDIG),
    .KEY_SCAN   (1),
    .WAIT_TICKS (WAIT_TICKS)
  ) dut (
    .clkinput   (clkinput),
    .rst        (rst),
    .seg_data   (seg_data),
    .dp         (dp),
    .led        (led),
    .brightness (brightness),
    .display_on (display_on),
    .clk        (sclk),
    .stb        (stb),
    .dio_out    (dio_out),
    .dio_oe     (dio_oe),
    .dio_in     (dio_in),
    .keys       (keys),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clkinput = ~clkinput;

  // Line decoder and key device, sampled mid-cycle.
  int         win_bits;
  int         win_wr;
  bit         read_win;
  logic [7:0] cur;
  logic       prev_clk;
  logic       prev_stb;
  always @(negedge clkinput) begin
    if (rst) begin
      win_bits = 0;
      win_wr   = 0;
      read_win = 0;
      cur      = 8'h00;
      dio_in   = 1'b0;
      prev_clk = 1'b1;
      prev_stb = 1'b1;
    end else begin
      if (prev_stb && !stb) begin
        win_bits = 0;
        win_wr   = 0;
        read_win = 0;
      end
      if (!stb && read_win && win_bits >= 8) begin
        if (prev_clk && !sclk) begin
          int b;
          b = win_bits - 8;
          dio_in = dev_key[b / 8][b % 8];
        end
        if (!sclk && dio_oe) oe_viol++;
      end
      if (!stb && !prev_clk && sclk) begin
        if (!(read_win && win_bits >= 8)) begin
          cur = {dio_out, cur[7:1]};
          if (win_bits % 8 == 7) begin
            wr_q.push_back(cur);
            win_wr++;
            if (win_bits == 7 && cur == 8'h42) read_win = 1;
          end
        end
        win_bits++;
      end
      if (!prev_stb && stb) win_q.push_back(win_wr);
      if (keys_valid) kv_cnt++;
      prev_clk = sclk;
      prev_stb = stb;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Expected write bytes of one frame and the keys the device will return.
  task automatic build_model();
    logic [7:0] d;
    exp_q.delete();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int p = 0; p < 8; p++) begin
      if (p < int'(NDIG)) begin
        d = seg_tab[seg_data[4*p +: 4]];
        exp_q.push_back({dp[p], d[6:0]});
        exp_q.push_back({7'b0, led[p]});
      end else begin
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
      end
    end
    d = 8'h80 + (display_on ? 8'h08 : 8'h00) + {5'b0, brightness};
    exp_q.push_back(d);
    exp_q.push_back(8'h42);
    exp_keys = {dev_key[3], dev_key[2], dev_key[1], dev_key[0]};
  endtask

  task automatic randomize_inputs();
    seg_data   = 16'($urandom);
    dp         = 4'($urandom);
    led        = 4'($urandom);
    brightness = 3'($urandom);
    display_on = 1'($urandom);
    for (int i = 0; i < 4; i++) dev_key[i] = 8'($urandom) | 8'h01;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int n = 0; n < 4000 && !seen; n++) begin
      @(posedge clkinput);
      #1;
      if (keys_valid) seen = 1;
    end
    chk("frame_done", 32'(seen), 32'd1);
  endtask

  task automatic check_frame();
    chk("byte_count", 32'(wr_q.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      if (i < wr_q.size()) chk($sformatf("byte%0d", i), 32'(wr_q[i]), 32'(old_q[i]));
    chk("win_count", 32'(win_q.size()), 32'd4);
    if (win_q.size() == 4) begin
      chk("win0_len", 32'(win_q[0]), 32'd1);
      chk("win1_len", 32'(win_q[1]), 32'd17);
      chk("win2_len", 32'(win_q[2]), 32'd1);
      chk("win3_len", 32'(win_q[3]), 32'd1);
    end
    chk("keys", keys, old_keys);
    chk("kv_pulses", 32'(kv_cnt), 32'd1);
    chk("oe_in_read", 32'(oe_viol), 32'd0);
  endtask

  task automatic clear_obs();
    wr_q.delete();
    win_q.delete();
    kv_cnt  = 0;
    oe_viol = 0;
  endtask

  initial begin
    rst = 1'b1;
    randomize_inputs();
    repeat (3) @(posedge clkinput);
    #1;
    chk("rst_clk", 32'(sclk), 32'd1);
    chk("rst_stb", 32'(stb), 32'd1);
    chk("rst_dio_out", 32'(dio_out), 32'd0);
    chk("rst_dio_oe", 32'(dio_oe), 32'd0);
    chk("rst_keys", keys, 32'h0);
    chk("rst_keys_valid", 32'(keys_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Frame 0: directed digit 0 and display fields, fixed key bytes.
    seg_data[3:0] = 4'hA;
    dp[0]         = 1'b1;
    led[0]        = 1'b1;
    brightness    = 3'd5;
    display_on    = 1'b1;
    dev_key[0] = 8'h11; dev_key[1] = 8'h22; dev_key[2] = 8'h44; dev_key[3] = 8'h88;
    build_model();
    rst = 1'b0;
    @(posedge clkinput); #1;
    chk("stb_cycle1", 32'(stb), 32'd1);
    @(posedge clkinput); #1;
    chk("stb_cycle2", 32'(stb), 32'd0);
    chk("clk_before_first_low", 32'(sclk), 32'd1);
    @(posedge clkinput); #1;
    chk("first_clk_low", 32'(sclk), 32'd0);
    chk("first_bit", 32'(dio_out), 32'd0);
    chk("first_oe", 32'(dio_oe), 32'd1);

    for (int f = 0; f < 5; f++) begin
      wait_frame();
      old_q    = exp_q;
      old_keys = exp_keys;
      randomize_inputs();
      if (f == 1) begin
        brightness = 3'd5;
        display_on = 1'b0;
      end
      build_model();
      repeat (2) @(posedge clkinput);
      #1;
      check_frame();
      if (f == 0 && wr_q.size() == 20) begin
        chk("cmd_write", 32'(wr_q[0]), 32'h40);
        chk("data0_seg_dp", 32'(wr_q[2]), 32'hF7);
        chk("data1_led", 32'(wr_q[3]), 32'h01);
        for (int i = 10; i < 18; i++) chk($sformatf("unpop%0d", i - 2), 32'(wr_q[i]), 32'h00);
        chk("disp_on", 32'(wr_q[18]), 32'h8D);
        chk("keys_fixed", keys, 32'h88442211);
      end
      if (f == 2 && wr_q.size() == 20) chk("disp_off", 32'(wr_q[18]), 32'h85);
      clear_obs();
    end

    // Reset while data byte 7 is on the wire.
    begin
      bit hit;
      hit = 0;
      for (int n = 0; n < 4000 && !hit; n++) begin
        @(posedge clkinput); #1;
        if (wr_q.size() >= 9) hit = 1;
      end
      chk("reach_byte7", 32'(hit), 32'd1);
    end
    repeat (3) @(posedge clkinput);
    #1;
    rst = 1'b1;
    @(posedge clkinput); #1;
    chk("mid_rst_clk", 32'(sclk), 32'd1);
    chk("mid_rst_stb", 32'(stb), 32'd1);
    chk("mid_rst_oe", 32'(dio_oe), 32'd0);
    chk("mid_rst_dio_out", 32'(dio_out), 32'd0);
    chk("mid_rst_keys", keys, 32'h0);
    chk("mid_rst_kv", 32'(keys_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    clear_obs();
    randomize_inputs();
    build_model();
    @(posedge clkinput); #1;
    rst = 1'b0;
    wait_frame();
    old_q    = exp_q;
    old_keys = exp_keys;
    repeat (2) @(posedge clkinput);
    #1;
    check_frame();
    if (wr_q.size() > 0) chk("restart_cmd", 32'(wr_q[0]), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
